lfsr_seq_ctrl: RTL
==================

LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 Parameter POLY_WIDTH, default 73, LFSR width in bits.
REQ-002 Parameter CNT_W, default 8, step-count field width.
REQ-003 Parameter BASE_ADDR, default 12'h0d7, address of seed word 0; words 1 and 2 are at BASE_ADDR+1 and BASE_ADDR+2.
REQ-004 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req[1:0]  input  2  per-requester run request, level, held until done or abort.
REQ-008 reseed[1:0]  input  2  per-requester: 1 = load seed before run.
REQ-009 seed0, seed1  input  POLY_WIDTH each  requester seeds.
REQ-010 cnt0, cnt1  input  CNT_W each  number of enable cycles requested.
REQ-011 abort  input  1  terminate current job.
REQ-012 gnt[1:0]  output  2  one-hot owner, held from grant to end of job.
REQ-013 done[1:0]  output  2  one-cycle completion pulse to owner.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 lfsr_write  output  1, lfsr_addr  output  12, lfsr_wdata  output  32  LFSR seed-load port.
REQ-016 lfsr_enable  output  1  LFSR step enable.
REQ-017 lfsr_dout  input  POLY_WIDTH  LFSR state.
REQ-018 key_vld  output  1, key_data  output  POLY_WIDTH, key_id  output  1  keystream output, tagged with the owner.

Function
REQ-019 FSM states SHALL be IDLE, LOAD0, LOAD1, LOAD2, RUN, DONE; all outputs are decoded from registered state and registered counters.
REQ-020 In IDLE with req != 0, the block SHALL grant one requester round-robin and latch its seed, cnt and reseed.
REQ-021 On simultaneous requests, the requester not granted last SHALL win; after reset the tie goes to requester 0.
REQ-022 Next state after grant: LOAD0 if latched reseed=1; else RUN if cnt != 0; else DONE.
REQ-023 LOAD0/1/2 SHALL each last one cycle, with lfsr_write=1, lfsr_addr=BASE_ADDR+k and lfsr_wdata as follows:
- LOAD0: seed[31:0].
- LOAD1: seed[63:32].
- LOAD2: seed[POLY_WIDTH-1:64], zero-extended to 32 bits.
REQ-024 After LOAD2 the FSM SHALL go to RUN if cnt != 0, else to DONE.
REQ-025 In RUN, lfsr_enable SHALL be 1 for exactly cnt consecutive cycles; the down-counter is loaded with cnt and leaves RUN when it reaches 1.
REQ-026 DONE SHALL last one cycle, assert done[owner]=1 and return to IDLE.
REQ-027 Back-to-back grants: the FSM SHALL spend at least one IDLE cycle between jobs.
REQ-028 lfsr_write and lfsr_enable SHALL never be high in the same cycle.
REQ-029 Keystream timing:
- key_vld SHALL equal lfsr_enable delayed one cycle.
- key_data SHALL equal lfsr_dout.
- key_id SHALL equal the owner delayed one cycle.
REQ-030 If abort=1 in any non-IDLE state, the next state SHALL be IDLE, with no done pulse and gnt cleared; write/enable drop on that edge, and a key_vld from the final enable cycle still occurs.
REQ-031 abort in IDLE SHALL be ignored and SHALL have priority over a same-cycle grant.
REQ-032 A requester that drops req mid-job SHALL NOT change the sequence; only abort terminates a job.
REQ-033 Latched seed and cnt SHALL be immune to input changes after grant.

Reset
REQ-034 While rst=1 at a clock edge, the block SHALL reset as follows:
- state=IDLE.
- gnt, done, busy, lfsr_write, lfsr_enable, key_vld = 0.
- lfsr_addr, lfsr_wdata, key_id = 0.
- round-robin pointer = requester 1 last granted.
- counter = 0.
REQ-035 Reset mid-job SHALL discard the job without a done pulse.

Verification
REQ-036 req=01, reseed0=1, seed0=73'h1_2345_6789_ABCD_EF01, cnt0=4 -> expected response:
- writes addr 0d7/0d8/0d9 with data 89ABCDEF01... split as [31:0]=ABCDEF01, [63:32]=23456789, [72:64]=00000001.
- then 4 enable cycles, 4 key_vld with key_id=0, one done[0] pulse.
REQ-037 req=11 held from reset -> expected response:
- grant order 0,1,0,1.
- each job bracketed by done.
- at least one IDLE cycle between jobs.
REQ-038 reseed1=0, cnt1=0 -> expected response: gnt[1], then DONE on the next cycle, with zero writes and zero enables.
REQ-039 cnt=200, abort raised on the 10th RUN cycle -> expected response: exactly 10 enable cycles, 10 key_vld, no done, busy=0 next cycle.
REQ-040 rst asserted during LOAD1 -> expected response: all outputs 0 next cycle, and the next tie resolves to requester 0.
REQ-041 Change seed0 and cnt0 one cycle after grant -> expected response: write data and enable count match the values captured at grant.

Source files
------------

// File: rtl/lfsr_seq_ctrl.sv
// Two-requester sequencer for an external LFSR: arbitrates ownership, optionally
// loads a seed over the three-word write port, then steps the LFSR for the requested count.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests
// LOAD0 | write seed[31:0] to BASE_ADDR
// LOAD1 | write seed[63:32] to BASE_ADDR+1
// LOAD2 | write seed[POLY_WIDTH-1:64] (zero-extended) to BASE_ADDR+2
// RUN   | step the LFSR once per cycle until the count expires
// DONE  | one-cycle completion pulse to the owner
module lfsr_seq_ctrl #(
    parameter int          POLY_WIDTH = 73,
    parameter int          CNT_W      = 8,
    parameter logic [11:0] BASE_ADDR  = 12'h0d7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            reseed,
    input  logic [POLY_WIDTH-1:0] seed0,
    input  logic [POLY_WIDTH-1:0] seed1,
    input  logic [CNT_W-1:0]      cnt0,
    input  logic [CNT_W-1:0]      cnt1,
    input  logic                  abort,
    output logic [1:0]            gnt,
    output logic [1:0]            done,
    output logic                  busy,
    output logic                  lfsr_write,
    output logic [11:0]           lfsr_addr,
    output logic [31:0]           lfsr_wdata,
    output logic                  lfsr_enable,
    input  logic [POLY_WIDTH-1:0] lfsr_dout,
    output logic                  key_vld,
    output logic [POLY_WIDTH-1:0] key_data,
    output logic                  key_id
);

    // The seed is carried as three 32-bit words, so POLY_WIDTH must lie in 65..96.
    localparam int PAD_W = 96;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD0,
        S_LOAD1,
        S_LOAD2,
        S_RUN,
        S_DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  owner;
    logic                  last_gnt;
    logic                  reseed_lat;
    logic [POLY_WIDTH-1:0] seed_lat;
    logic [CNT_W-1:0]      cnt_lat;
    logic [CNT_W-1:0]      counter;

    logic                  grant_take;
    logic                  grant_sel;
    logic [CNT_W-1:0]      cnt_sel;
    logic [PAD_W-1:0]      seed_pad;
    logic [1:0]            owner_oh;

    // Round-robin: a tie goes to whichever requester was not granted last.
    always_comb begin
        grant_sel = 1'b0;
        case (req)
            2'b01:   grant_sel = 1'b0;
            2'b10:   grant_sel = 1'b1;
            2'b11:   grant_sel = ~last_gnt;
            default: grant_sel = 1'b0;
        endcase
        cnt_sel = grant_sel ? cnt1 : cnt0;
    end

    always_comb begin
        state_nxt  = state;
        grant_take = 1'b0;
        case (state)
            S_IDLE: begin
                if (!abort && (req != 2'b00)) begin
                    grant_take = 1'b1;
                    if (reseed[grant_sel])
                        state_nxt = S_LOAD0;
                    else if (cnt_sel != '0)
                        state_nxt = S_RUN;
                    else
                        state_nxt = S_DONE;
                end
            end
            S_LOAD0: state_nxt = S_LOAD1;
            S_LOAD1: state_nxt = S_LOAD2;
            S_LOAD2: state_nxt = (cnt_lat != '0) ? S_RUN : S_DONE;
            S_RUN: begin
                if (counter <= CNT_W'(1))
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort && (state != S_IDLE))
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            last_gnt   <= 1'b1;
            reseed_lat <= 1'b0;
            seed_lat   <= '0;
            cnt_lat    <= '0;
            counter    <= '0;
            key_vld    <= 1'b0;
            key_id     <= 1'b0;
        end else begin
            state   <= state_nxt;
            key_vld <= lfsr_enable;
            key_id  <= owner;
            if (grant_take) begin
                owner      <= grant_sel;
                last_gnt   <= grant_sel;
                reseed_lat <= reseed[grant_sel];
                seed_lat   <= grant_sel ? seed1 : seed0;
                cnt_lat    <= cnt_sel;
            end
            // Down-counter is armed on entry to RUN and stepped while in RUN.
            if (grant_take && (state_nxt == S_RUN))
                counter <= cnt_sel;
            else if ((state == S_LOAD2) && (state_nxt == S_RUN))
                counter <= cnt_lat;
            else if (state == S_RUN)
                counter <= counter - CNT_W'(1);
        end
    end

    always_comb begin
        seed_pad                   = '0;
        seed_pad[POLY_WIDTH-1:0]   = seed_lat;
        owner_oh                   = owner ? 2'b10 : 2'b01;

        busy        = (state != S_IDLE);
        gnt         = busy ? owner_oh : 2'b00;
        done        = (state == S_DONE) ? owner_oh : 2'b00;
        lfsr_enable = (state == S_RUN);
        lfsr_write  = 1'b0;
        lfsr_addr   = '0;
        lfsr_wdata  = '0;
        case (state)
            S_LOAD0: begin
                lfsr_write = 1'b1;
                lfsr_addr  = BASE_ADDR;
                lfsr_wdata = seed_pad[31:0];
            end
            S_LOAD1: begin
                lfsr_write = 1'b1;
                lfsr_addr  = BASE_ADDR + 12'd1;
                lfsr_wdata = seed_pad[63:32];
            end
            S_LOAD2: begin
                lfsr_write = 1'b1;
                lfsr_addr  = BASE_ADDR + 12'd2;
                lfsr_wdata = seed_pad[95:64];
            end
            default: begin
                lfsr_write = 1'b0;
            end
        endcase
        key_data = lfsr_dout;
    end

endmodule
